cci_tx1_arbiter: RTL and testbench
==================================

CCI_TX1_ARBITER -- requirements
Module: cci_tx1_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, gives the number of write requesters (2..4).
REQ-002 Parameter MAX_OUTST, default 64, gives the maximum outstanding writes per requester (power of 2, at most 256).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port sys_reset, input, 1: reset, asynchronous and active-high.
REQ-005 Port lp_initdone, input, 1: link init complete.
REQ-006 Port tx_c1_almostfull, input, 1: TX1 backpressure.
REQ-007 Ports req_valid / req_ready, input / output, NUM_REQ each: per-requester handshake.
REQ-008 Ports req_header / req_data, input, NUM_REQ x 61 / NUM_REQ x 512: per-requester TX1 header and data.
REQ-009 Ports tx_c1_wrvalid / tx_c1_header / tx_c1_data, output, 1 / 61 / 512: the shared CCI TX1 channel.
REQ-010 Ports rx_c0_wrvalid / rx_c0_header and rx_c1_wrvalid / rx_c1_header, input, 1 / 18 each: write responses.
REQ-011 Ports resp_valid / resp_mdata, output, NUM_REQ / NUM_REQ x 14: routed write responses.
REQ-012 Port outst_cnt, output, NUM_REQ x 9: per-requester outstanding-write count.

Function
REQ-013 The block SHALL have the FSM states WAIT_INIT, RUN and THROTTLE.
REQ-014 The FSM SHALL go from WAIT_INIT to RUN when lp_initdone=1.
REQ-015 The FSM SHALL go from RUN to THROTTLE when tx_c1_almostfull=1, and from THROTTLE to RUN when it is 0.
REQ-016 The FSM SHALL go from any state to WAIT_INIT when lp_initdone=0.
REQ-017 req_ready[i] SHALL be combinational and asserted only when all of these hold: state is RUN, tx_c1_almostfull=0, req_valid[i]=1, outst_cnt[i] < MAX_OUTST, and i is the round-robin winner.
REQ-018 At most one req_ready bit SHALL be asserted in any cycle.
REQ-019 Round-robin: the search SHALL start at rr_ptr and go upward with wrap; rr_ptr SHALL become winner+1 (mod NUM_REQ) after each transfer and SHALL hold otherwise.
REQ-020 A transfer occurs when req_valid[i] & req_ready[i]; tx_c1_wrvalid, tx_c1_header and tx_c1_data SHALL be registered and valid the next cycle (latency 1).
REQ-021 tx_c1_wrvalid SHALL be a one-cycle pulse per transfer.
REQ-022 The forwarded header SHALL equal req_header with mdata[13:12] replaced by the requester index; requesters use mdata[11:0] only.
REQ-023 A write fence (type field = WRFENCE) SHALL be arbitrated like a write and SHALL count as outstanding.
REQ-024 A response on rx_cX_wrvalid SHALL route to requester mdata[13:12].
REQ-025 Routed responses SHALL appear as resp_valid one cycle later, with resp_mdata equal to the response mdata with [13:12] cleared.
REQ-026 When C0 and C1 responses arrive in the same cycle, C0 SHALL be forwarded first and C1 one cycle later through a one-entry skid register; no response SHALL be lost.
REQ-027 outst_cnt[i] SHALL be incremented on transfer and decremented on each routed response; simultaneous issue and response SHALL give a net change of 0; two responses in one cycle SHALL decrement by 2.
REQ-028 A response arriving while outst_cnt[i]=0 SHALL leave the counter at 0 and set a sticky underflow flag, which SHALL be checked by an assertion.
REQ-029 Counters SHALL keep their value through WAIT_INIT, so responses are still counted after lp_initdone drops.
REQ-030 A transfer accepted in the cycle almostfull rises SHALL still be issued; at most 1 request SHALL be issued after almostfull is sampled high.

Reset
REQ-031 On sys_reset, the FSM SHALL go to WAIT_INIT, rr_ptr to 0 and all counters to 0; the skid register and underflow flag SHALL be cleared.
REQ-032 On sys_reset, tx_c1_wrvalid, resp_valid and req_ready SHALL be 0, and tx_c1_header/data and resp_mdata SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL discard the pending registered request; no partial pulse SHALL appear.

Structure
REQ-034 The package ase_cci_pkg SHALL hold these constants: TX header width 61, RX header width 18, data width 512, mdata range, TX type range, WRLINE/WRTHRU/WRFENCE codes, and the FSM state enum.
REQ-035 A sub-module rr_arbiter (NUM_REQ request vector, rr_ptr, one-hot grant) SHALL be instantiated once.

Verification
REQ-036 Bench: 4 requesters all valid, almostfull=0 -> grants in the order 0,1,2,3,0; one tx_c1_wrvalid per cycle; mdata[13:12] = 0,1,2,3.
REQ-037 Bench: almostfull=1 for 5 cycles during traffic -> no req_ready during those cycles; the FSM is in THROTTLE; traffic resumes the cycle after almostfull=0.
REQ-038 Bench: simultaneous rx_c0 and rx_c1 wrvalid for requesters 1 and 2 -> resp_valid[1] at t+1 and resp_valid[2] at t+2; both counters decremented.
REQ-039 Bench: requester 0 issues 64 writes with no responses -> req_ready[0] stays low while other requesters keep being served; after one response, requester 0 is granted again.
REQ-040 Bench: lp_initdone=0 mid-stream -> WAIT_INIT, no grants, counters held; then sys_reset pulse -> all outputs 0 and rr_ptr = 0.

Source files
------------

// File: rtl/ase_cci_pkg.sv
// ase_cci_pkg: CCI TX1/RX widths, header field positions, request codes and arbiter FSM states.
package ase_cci_pkg;
    localparam int TX_HDR_W  = 61;
    localparam int RX_HDR_W  = 18;
    localparam int DATA_W    = 512;
    localparam int MDATA_HI  = 13;
    localparam int MDATA_LO  = 0;
    localparam int MDATA_W   = MDATA_HI - MDATA_LO + 1;
    localparam int RID_LO    = 12;
    localparam int TXTYPE_HI = 55;
    localparam int TXTYPE_LO = 52;
    localparam int CNT_W     = 9;
    localparam logic [3:0] WRLINE  = 4'h2;
    localparam logic [3:0] WRTHRU  = 4'h3;
    localparam logic [3:0] WRFENCE = 4'h5;
    typedef enum logic [1:0] {WAIT_INIT, RUN, THROTTLE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; search starts at ptr and wraps upward.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant
);
    logic [1:0] idx;
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = 2'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cci_tx1_arbiter.sv
// cci_tx1_arbiter: round-robin arbitration of write requesters onto CCI TX1,
// write-response routing and per-requester outstanding-write tracking.
import ase_cci_pkg::*;

module cci_tx1_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 64
) (
    input  logic                         clk,
    input  logic                         sys_reset,
    input  logic                         lp_initdone,
    input  logic                         tx_c1_almostfull,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*TX_HDR_W-1:0]  req_header,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic                         tx_c1_wrvalid,
    output logic [TX_HDR_W-1:0]          tx_c1_header,
    output logic [DATA_W-1:0]            tx_c1_data,
    input  logic                         rx_c0_wrvalid,
    input  logic [RX_HDR_W-1:0]          rx_c0_header,
    input  logic                         rx_c1_wrvalid,
    input  logic [RX_HDR_W-1:0]          rx_c1_header,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [NUM_REQ*MDATA_W-1:0]   resp_mdata,
    output logic [NUM_REQ*CNT_W-1:0]     outst_cnt
);
    state_t                     state_q, state_d;
    logic [1:0]                 rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]         elig, grant;
    logic [1:0]                 win;
    logic                       fire;
    logic                       tx_vld_q, tx_vld_d;
    logic [TX_HDR_W-1:0]        tx_hdr_q, tx_hdr_d;
    logic [DATA_W-1:0]          tx_data_q, tx_data_d;
    logic                       skid_vld_q, skid_vld_d;
    logic [MDATA_W-1:0]         skid_md_q, skid_md_d;
    logic [MDATA_W-1:0]         c0_md, c1_md, fwd_md;
    logic                       fwd_vld;
    logic [NUM_REQ-1:0]         rsp_vld_q, rsp_vld_d;
    logic [NUM_REQ*MDATA_W-1:0] rsp_md_q, rsp_md_d;
    logic [NUM_REQ*CNT_W-1:0]   cnt_q, cnt_d;
    logic                       uflow_q, uflow_d;
    logic [CNT_W-1:0]           sum;
    logic [1:0]                 dec;
    logic                       unused_rsp_type;

    rr_arbiter #(.N(NUM_REQ)) u_rr (.req(elig), .ptr(rr_ptr_q), .grant(grant));

    always_comb begin
        elig = '0;
        win  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (cnt_q[i*CNT_W +: CNT_W] < CNT_W'(MAX_OUTST));
            if (grant[i]) win = 2'(i);
        end
        req_ready = (state_q == RUN && !tx_c1_almostfull) ? grant : '0;
        fire      = |req_ready;
        state_d   = !lp_initdone ? WAIT_INIT : (state_q == WAIT_INIT) ? RUN :
                    tx_c1_almostfull ? THROTTLE : RUN;
        rr_ptr_d  = !fire ? rr_ptr_q : (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
        tx_vld_d  = fire;
        tx_data_d = fire ? req_data[win*DATA_W +: DATA_W] : tx_data_q;
        tx_hdr_d  = tx_hdr_q;
        if (fire) begin
            tx_hdr_d = req_header[win*TX_HDR_W +: TX_HDR_W];
            tx_hdr_d[RID_LO +: 2] = win;
        end
        // Skid holds the older pending response, so it is always forwarded first
        c0_md      = rx_c0_header[MDATA_HI:MDATA_LO];
        c1_md      = rx_c1_header[MDATA_HI:MDATA_LO];
        fwd_vld    = skid_vld_q || rx_c0_wrvalid || rx_c1_wrvalid;
        fwd_md     = skid_vld_q ? skid_md_q : rx_c0_wrvalid ? c0_md : c1_md;
        skid_vld_d = skid_vld_q ? (rx_c0_wrvalid || rx_c1_wrvalid) : (rx_c0_wrvalid && rx_c1_wrvalid);
        skid_md_d  = (skid_vld_q && rx_c0_wrvalid) ? c0_md :
                     (rx_c1_wrvalid && (skid_vld_q || rx_c0_wrvalid)) ? c1_md : skid_md_q;
        rsp_vld_d  = '0;
        rsp_md_d   = rsp_md_q;
        cnt_d      = cnt_q;
        uflow_d    = uflow_q;
        sum        = '0;
        dec        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_vld_d[i] = fwd_vld && (fwd_md[RID_LO +: 2] == 2'(i));
            if (rsp_vld_d[i]) rsp_md_d[i*MDATA_W +: MDATA_W] = {2'b00, fwd_md[RID_LO-1:0]};
            // Counters move on response arrival, not on forwarding, so both channels count
            dec = {1'b0, rx_c0_wrvalid && (c0_md[RID_LO +: 2] == 2'(i))} +
                  {1'b0, rx_c1_wrvalid && (c1_md[RID_LO +: 2] == 2'(i))};
            sum = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(fire && (win == 2'(i)));
            uflow_d = uflow_d || (sum < CNT_W'(dec));
            cnt_d[i*CNT_W +: CNT_W] = (sum < CNT_W'(dec)) ? '0 : sum - CNT_W'(dec);
        end
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q    <= WAIT_INIT;
            rr_ptr_q   <= '0;
            tx_vld_q   <= 1'b0;
            tx_hdr_q   <= '0;
            tx_data_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_md_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_md_q   <= '0;
            cnt_q      <= '0;
            uflow_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_vld_q   <= tx_vld_d;
            tx_hdr_q   <= tx_hdr_d;
            tx_data_q  <= tx_data_d;
            skid_vld_q <= skid_vld_d;
            skid_md_q  <= skid_md_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_md_q   <= rsp_md_d;
            cnt_q      <= cnt_d;
            uflow_q    <= uflow_d;
        end
    end

    assign tx_c1_wrvalid   = tx_vld_q;
    assign tx_c1_header    = tx_hdr_q;
    assign tx_c1_data      = tx_data_q;
    assign resp_valid      = rsp_vld_q;
    assign resp_mdata      = rsp_md_q;
    assign outst_cnt       = cnt_q;
    assign unused_rsp_type = ^{rx_c0_header[RX_HDR_W-1:MDATA_HI+1], rx_c1_header[RX_HDR_W-1:MDATA_HI+1]};

    assert property (@(posedge clk) disable iff (sys_reset) !uflow_q);
    assert property (@(posedge clk) disable iff (sys_reset) $onehot0(req_ready));
endmodule

// File: tb/tb_cci_tx1_arbiter.sv
// tb_cci_tx1_arbiter: directed and randomized traffic checked every cycle against a
// transaction-level model (counters, round-robin pointer, response queue).
module tb_cci_tx1_arbiter;
    import ase_cci_pkg::*;
    localparam int N  = 4;
    localparam int MO = 64;

    logic             clk = 1'b0;
    logic             sys_reset, lp_initdone, af;
    logic [N-1:0]     req_valid, req_ready;
    logic [N*61-1:0]  req_header;
    logic [N*512-1:0] req_data;
    logic             tx_c1_wrvalid;
    logic [60:0]      tx_c1_header;
    logic [511:0]     tx_c1_data;
    logic             rx_c0_wrvalid, rx_c1_wrvalid;
    logic [17:0]      rx_c0_header, rx_c1_header;
    logic [N-1:0]     resp_valid;
    logic [N*14-1:0]  resp_mdata;
    logic [N*9-1:0]   outst_cnt;

    state_t       m_state;
    int           m_ptr;
    int           m_cnt[N];
    logic         m_txv;
    logic [60:0]  m_txh;
    logic [511:0] m_txd;
    logic [13:0]  rq[$];
    logic [N-1:0] m_rv;
    logic [13:0]  m_rm[N];

    logic [N-1:0]    s_ready, s_rv;
    logic            s_txv;
    logic [60:0]     s_txh;
    logic [511:0]    s_txd;
    logic [N*9-1:0]  s_cnt;
    logic [N*14-1:0] s_rm;
    state_t          s_state;
    logic [1:0]      s_ptr;

    int checks = 0;
    int errors = 0;

    cci_tx1_arbiter #(.NUM_REQ(N), .MAX_OUTST(MO)) dut (
        .clk(clk), .sys_reset(sys_reset), .lp_initdone(lp_initdone), .tx_c1_almostfull(af),
        .req_valid(req_valid), .req_ready(req_ready), .req_header(req_header), .req_data(req_data),
        .tx_c1_wrvalid(tx_c1_wrvalid), .tx_c1_header(tx_c1_header), .tx_c1_data(tx_c1_data),
        .rx_c0_wrvalid(rx_c0_wrvalid), .rx_c0_header(rx_c0_header),
        .rx_c1_wrvalid(rx_c1_wrvalid), .rx_c1_header(rx_c1_header),
        .resp_valid(resp_valid), .resp_mdata(resp_mdata), .outst_cnt(outst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_state = WAIT_INIT;
        m_ptr   = 0;
        m_txv   = 1'b0;
        m_txh   = '0;
        m_txd   = '0;
        m_rv    = '0;
        rq.delete();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_rm[i]  = '0;
        end
    endtask

    function automatic int m_winner();
        if (m_state != RUN || af) return -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i] && m_cnt[i] < MO) return i;
        end
        return -1;
    endfunction

    task automatic cycle();
        int w;
        logic [N-1:0] er;
        logic [13:0] md;
        if (sys_reset) m_reset();
        #3;
        w  = m_winner();
        er = (w >= 0) ? (N'(1) << w) : '0;
        s_ready = req_ready; s_rv = resp_valid; s_txv = tx_c1_wrvalid; s_txh = tx_c1_header;
        s_txd = tx_c1_data; s_cnt = outst_cnt; s_rm = resp_mdata; s_state = dut.state_q; s_ptr = dut.rr_ptr_q;
        chk("req_ready", 512'(req_ready), 512'(er));
        chk("tx_wrvalid", 512'(tx_c1_wrvalid), 512'(m_txv));
        if (m_txv) begin
            chk("tx_header", 512'(tx_c1_header), 512'(m_txh));
            chk("tx_data", tx_c1_data, m_txd);
        end
        chk("resp_valid", 512'(resp_valid), 512'(m_rv));
        for (int i = 0; i < N; i++) begin
            if (m_rv[i]) chk("resp_mdata", 512'(resp_mdata[i*14 +: 14]), 512'(m_rm[i]));
            chk("outst_cnt", 512'(outst_cnt[i*9 +: 9]), 512'(m_cnt[i]));
        end
        chk("state", 512'(dut.state_q), 512'(m_state));
        chk("rr_ptr", 512'(dut.rr_ptr_q), 512'(m_ptr));
        if (sys_reset) m_reset();
        else begin
            m_txv = (w >= 0);
            if (w >= 0) begin
                m_txh = req_header[w*61 +: 61];
                m_txh[13:12] = 2'(w);
                m_txd = req_data[w*512 +: 512];
                m_cnt[w]++;
                m_ptr = (w + 1) % N;
            end
            if (rx_c0_wrvalid) begin m_cnt[rx_c0_header[13:12]]--; rq.push_back(rx_c0_header[13:0]); end
            if (rx_c1_wrvalid) begin m_cnt[rx_c1_header[13:12]]--; rq.push_back(rx_c1_header[13:0]); end
            m_rv = '0;
            if (rq.size() > 0) begin
                md = rq.pop_front();
                m_rv[md[13:12]] = 1'b1;
                m_rm[md[13:12]] = {2'b00, md[11:0]};
            end
            m_state = !lp_initdone ? WAIT_INIT : (m_state == WAIT_INIT) ? RUN : af ? THROTTLE : RUN;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        logic [63:0] t;
        int r;
        for (int i = 0; i < N; i++) begin
            t = {$urandom, $urandom};
            r = $urandom_range(0, 2);
            t[TXTYPE_HI:TXTYPE_LO] = (r == 0) ? WRLINE : (r == 1) ? WRTHRU : WRFENCE;
            req_header[i*61 +: 61] = t[60:0];
            for (int j = 0; j < 16; j++) req_data[i*512 + j*32 +: 32] = $urandom;
        end
    endtask

    task automatic no_resp();
        rx_c0_wrvalid = 1'b0; rx_c1_wrvalid = 1'b0;
        rx_c0_header = '0; rx_c1_header = '0;
    endtask

    task automatic rand_resp(input int pct);
        int avail[N];
        int room, s, r;
        logic [17:0] h;
        for (int i = 0; i < N; i++) avail[i] = m_cnt[i];
        room = 2 - rq.size();
        no_resp();
        for (int c = 0; c < 2; c++) begin
            if (room > 0 && $urandom_range(0, 99) < pct) begin
                s = $urandom_range(0, N - 1);
                r = -1;
                for (int k = 0; k < N; k++) if (r < 0 && avail[(s + k) % N] > 0) r = (s + k) % N;
                if (r >= 0) begin
                    avail[r]--;
                    room--;
                    h = {4'(4'h1), 2'(r), 12'($urandom)};
                    if (c == 0) begin rx_c0_wrvalid = 1'b1; rx_c0_header = h; end
                    else begin rx_c1_wrvalid = 1'b1; rx_c1_header = h; end
                end
            end
        end
    endtask

    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int busy, held;
    logic seen;

    initial begin
        sys_reset = 1'b1; lp_initdone = 1'b1; af = 1'b0; req_valid = '1;
        req_header = '0; req_data = '0;
        no_resp();
        rand_payload();
        m_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) cycle();
        chk("rst_ready", 512'(s_ready), 512'(0));
        chk("rst_txv", 512'(s_txv), 512'(0));
        chk("rst_hdr", 512'(s_txh), 512'(0));
        chk("rst_rv", 512'(s_rv), 512'(0));
        chk("rst_cnt", 512'(s_cnt), 512'(0));
        chk("rst_state", 512'(s_state), 512'(WAIT_INIT));

        sys_reset = 1'b0; req_valid = '0;
        cycle();
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            rand_payload();
            cycle();
            if (k < 5) chk("grant_order", 512'(oh2i(s_ready)), 512'(exp_seq[k]));
            if (k > 0) begin
                chk("tx_pulse", 512'(s_txv), 512'(1));
                chk("tx_reqid", 512'(s_txh[13:12]), 512'(exp_seq[k-1]));
            end
        end

        af = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_payload();
            cycle();
            chk("throttle_ready", 512'(s_ready), 512'(0));
            if (k > 0) chk("throttle_state", 512'(s_state), 512'(THROTTLE));
        end
        af = 1'b0;
        cycle();
        chk("throttle_exit_ready", 512'(s_ready), 512'(0));
        cycle();
        chk("resume", 512'(s_ready != 0), 512'(1));

        req_valid = '0;
        cycle();
        rx_c0_wrvalid = 1'b1; rx_c0_header = {4'h1, 2'd1, 12'h0AB};
        rx_c1_wrvalid = 1'b1; rx_c1_header = {4'h1, 2'd2, 12'h0CD};
        cycle();
        no_resp();
        cycle();
        chk("dual_rv1", 512'(s_rv), 512'(4'b0010));
        chk("dual_md1", 512'(s_rm[14 +: 14]), 512'(14'h0AB));
        chk("dual_cnt1", 512'(s_cnt[9 +: 9]), 512'(1));
        chk("dual_cnt2", 512'(s_cnt[18 +: 9]), 512'(1));
        cycle();
        chk("dual_rv2", 512'(s_rv), 512'(4'b0100));
        chk("dual_md2", 512'(s_rm[28 +: 14]), 512'(14'h0CD));

        req_valid = 4'b0001;
        busy = 0;
        while (m_cnt[0] < MO && busy < 80) begin
            rand_payload();
            cycle();
            busy++;
        end
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            rand_payload();
            cycle();
            if (k == 0) chk("cnt0_full", 512'(s_cnt[8:0]), 512'(MO));
            chk("full_blocked", 512'(s_ready[0]), 512'(0));
            chk("others_served", 512'(s_ready[3:1] != 0), 512'(1));
        end
        rx_c0_wrvalid = 1'b1; rx_c0_header = {4'h1, 2'd0, 12'h123};
        cycle();
        no_resp();
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (s_ready[0]) seen = 1'b1;
        end
        chk("req0_regrant", 512'(seen), 512'(1));

        for (int k = 0; k < 3000; k++) begin
            sys_reset   = ($urandom_range(0, 499) == 0);
            lp_initdone = ($urandom_range(0, 63) != 0);
            af          = ($urandom_range(0, 7) == 0);
            req_valid   = N'($urandom);
            rand_payload();
            rand_resp(70);
            cycle();
        end

        sys_reset = 1'b0; lp_initdone = 1'b1; af = 1'b0; req_valid = '0;
        busy = 0;
        while ((m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3] > 0 || rq.size() > 0) && busy < 400) begin
            rand_resp(100);
            cycle();
            busy++;
        end
        chk("drained", 512'(busy < 400), 512'(1));

        no_resp();
        req_valid = '1;
        for (int k = 0; k < 3; k++) begin rand_payload(); cycle(); end
        lp_initdone = 1'b0;
        held = 0;
        for (int k = 0; k < 4; k++) begin
            rand_payload();
            cycle();
            if (k == 1) held = int'(s_cnt);
            if (k > 0) begin
                chk("init_drop_ready", 512'(s_ready), 512'(0));
                chk("init_drop_state", 512'(s_state), 512'(WAIT_INIT));
            end
            if (k == 3) chk("init_drop_held", 512'(s_cnt), 512'(held));
        end
        lp_initdone = 1'b1;
        cycle();
        cycle();
        chk("pre_reset_grant", 512'(s_ready != 0), 512'(1));
        sys_reset = 1'b1;
        cycle();
        chk("mid_rst_txv", 512'(s_txv), 512'(0));
        chk("mid_rst_hdr", 512'(s_txh), 512'(0));
        chk("mid_rst_data", s_txd, 512'(0));
        chk("mid_rst_ready", 512'(s_ready), 512'(0));
        chk("mid_rst_rv", 512'(s_rv), 512'(0));
        chk("mid_rst_rm", 512'(s_rm), 512'(0));
        chk("mid_rst_cnt", 512'(s_cnt), 512'(0));
        chk("mid_rst_ptr", 512'(s_ptr), 512'(0));
        sys_reset = 1'b0;
        for (int k = 0; k < 3; k++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
